ethernet_tx_rx: RTL and testbench
=================================

# ethernet_tx_rx

- Single-clock Ethernet-style framer with an internal loopback deframer.
- TX side:
  - Buffers a payload burst.
  - Emits a byte-wide frame on `tx_data_out`: preamble, SFD, destination MAC, source MAC, length, payload, CRC-32 FCS.
- RX side:
  - Parses that byte stream internally, checks address and FCS, and stores the payload.
  - Hands the payload to the consumer through a valid/ready interface.
- Used as a self-contained link-layer test and bring-up block.

## Interface
- `FIFO_DEPTH`, default 64: maximum payload bytes per frame; sets TX and RX buffer depth.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `tx_start`  in  1  one-cycle frame start request.
- `tx_data_in`  in  8  payload byte.
- `tx_data_valid`  in  1  `tx_data_in` valid.
- `tx_ready`  out  1  payload byte accepted when `tx_data_valid && tx_ready`.
- `tx_done`  out  1  one-cycle pulse after the last FCS byte.
- `tx_data_out`  out  8  serialized frame byte; 0x00 when not transmitting.
- `rx_data_out`  out  8  received payload byte (first-word fall-through).
- `rx_data_valid`  out  1  `rx_data_out` holds a validated payload byte.
- `rx_data_ready`  in  1  consumer accepts the byte when `rx_data_valid && rx_data_ready`.
- `src_mac`  in  48  source MAC; latched on an accepted `tx_start`.
- `dest_mac`  in  48  destination MAC; latched on an accepted `tx_start`; also the RX match address.

## Operation
- **TX states:** IDLE → LOAD → PREAMBLE(7) → SFD → DST(6) → SRC(6) → LEN(2) → PAYLOAD(N) → FCS(4) → DONE → IDLE.
- **IDLE:**
  - `tx_start` is accepted only if the RX buffer is empty; it then latches both MACs and moves to LOAD.
  - `tx_data_valid` is ignored in IDLE.
- **LOAD:**
  - Writes each accepted byte to the TX buffer.
  - Ends on the first cycle with `tx_data_valid=0` after at least 1 byte has been accepted, or when N reaches `FIFO_DEPTH`.
  - With 0 bytes accepted, it waits indefinitely.
- **Frame bytes, in order:**
  - Preamble: 0x55 ×7.
  - SFD: 0xD5.
  - Destination MAC, bits [47:40] first.
  - Source MAC, bits [47:40] first.
  - Length N as 16 bits, MSB first.
  - Payload bytes, in arrival order.
  - FCS.
- No padding to 46 bytes.
- **FCS:**
  - IEEE CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement.
  - Computed over destination MAC through payload.
  - Sent least-significant byte first.
- **DONE:** `tx_done`=1 for one cycle.
- **`tx_ready`** (combinational):
  - 1 in IDLE when the RX buffer is empty.
  - 1 in LOAD while N < `FIFO_DEPTH`.
  - 0 otherwise.
- **RX states:** HUNT → DST → SRC → LEN → PAYLOAD → FCS → CHECK.
  - RX samples `tx_data_out` only on cycles qualified by an internal TX byte strobe.
  - HUNT waits for 0xD5 following at least one 0x55.
  - PAYLOAD bytes go to the RX buffer.
  - CHECK commits the buffered payload only if the received destination equals `dest_mac` and the received FCS equals the recomputed CRC; otherwise it discards the payload.
  - After CHECK, RX returns to HUNT.
- **RX output:**
  - `rx_data_valid`=1 while committed bytes remain.
  - Each handshake advances the read pointer.
  - Bytes are delivered in order, with no loss or duplication under arbitrary `rx_data_ready` patterns.
- A `tx_start` while TX is not IDLE is ignored.

## Timing
- **Reset:**
  - All state machines go to IDLE/HUNT; buffers are emptied.
  - `tx_done`=0, `tx_data_out`=0x00, `rx_data_out`=0x00, `rx_data_valid`=0.
  - `tx_ready`=1 from the first cycle.
- **Reset mid-frame:** aborts the frame and drops all buffered data.
- **Frame length:** N+26 cycles, one byte per cycle. The first preamble byte appears on the cycle after LOAD ends.
- **End of frame:**
  - `tx_done` is high on the cycle after the last FCS byte.
  - The RX commit happens on that same cycle.
  - `rx_data_valid` rises on the next cycle.
- **Registered outputs:** `tx_data_out`, `tx_done`, `rx_data_valid`. `rx_data_out` is the buffer read of the head entry.

## Structure
- **Package `eth_pkg`:**
  - TX and RX state enums.
  - Constants: PREAMBLE_BYTE 0x55, PREAMBLE_LEN 7, SFD 0xD5, CRC_POLY 0xEDB88320, CRC_INIT 0xFFFFFFFF, header byte counts.
- **Sub-module `eth_crc32_step`:**
  - Combinational: takes the 32-bit CRC and an 8-bit byte, produces the next CRC.
  - Instantiated once in TX and once in RX.
- **Buffers:** TX and RX buffers are inline arrays of `FIFO_DEPTH`×8 with pointers.

## Test plan
- **Nominal frame:**
  - Stimulus: MACs 0x112233445566 (src) / 0xAABBCCDDEEFF (dest); `tx_start` pulse, then 16 bytes 0xBA..0xC9.
  - `tx_data_out` must be 55×7, D5, AA BB CC DD EE FF, 11 22 33 44 55 66, 00 10, BA..C9, then FCS matching the reference model.
  - `tx_done` must pulse once, 42 bytes after the frame starts.
  - With `rx_data_ready`=1 after `tx_done`, RX must return 0xBA..0xC9 in order.
- **RX backpressure:** toggle `rx_data_ready` randomly → the same 16 bytes, no duplicates or gaps; `rx_data_valid` drops after the 16th.
- **Full payload:** 70 valid bytes → `tx_ready` drops after 64, length field = 00 40, and RX returns exactly 64 bytes.
- **Busy and pending guards:**
  - `tx_start` during PAYLOAD → ignored; the frame is unchanged.
  - `tx_start` while the RX buffer is still undrained → ignored, with `tx_ready`=0.
- **Reset mid-frame:** `rst`=0 during SRC → all outputs at their reset values next cycle, and a following frame is correct.
- **Single-byte payload:** 0x00 → 27-byte frame, length 00 01, RX returns one byte 0x00.

Source files
------------

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared state encodings and framing constants for ethernet_tx_rx
package eth_pkg;
    typedef enum logic [3:0] {
        TX_IDLE, TX_LOAD, TX_PRE, TX_SFD, TX_DST, TX_SRC, TX_LEN, TX_PAY, TX_FCS, TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_HUNT, RX_DST, RX_SRC, RX_LEN, RX_PAY, RX_FCS, RX_CHECK
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [2:0]  PREAMBLE_LEN  = 3'd7;
    localparam logic [7:0]  SFD           = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [2:0]  MAC_BYTES     = 3'd6;
    localparam logic [2:0]  LEN_BYTES     = 3'd2;
    localparam logic [2:0]  FCS_BYTES     = 3'd4;
endpackage

// File: rtl/eth_crc32_step.sv
// rtl/eth_crc32_step.sv - one byte of reflected IEEE CRC-32
module eth_crc32_step
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/ethernet_tx_rx.sv
// rtl/ethernet_tx_rx.sv - byte-wide frame generator with internal loopback deframer
module ethernet_tx_rx
    import eth_pkg::*;
#(
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [7:0]  tx_data_in,
    input  logic        tx_data_valid,
    output logic        tx_ready,
    output logic        tx_done,
    output logic [7:0]  tx_data_out,
    output logic [7:0]  rx_data_out,
    output logic        rx_data_valid,
    input  logic        rx_data_ready,
    input  logic [47:0] src_mac,
    input  logic [47:0] dest_mac
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    tx_state_t     tx_state;
    logic [2:0]    tx_cnt;
    logic [LW-1:0] tx_len, tx_rd;
    logic [7:0]    tx_buf [FIFO_DEPTH];
    logic [47:0]   dst_l;
    logic [111:0]  hdr;
    logic [31:0]   tx_crc, tx_crc_next;
    logic [7:0]    tx_crc_byte;
    logic          tx_strobe;

    rx_state_t     rx_state;
    logic [2:0]    rx_cnt;
    logic          rx_seen_pre, rx_commit;
    logic [47:0]   rx_dst;
    logic [15:0]   rx_len;
    logic [31:0]   rx_fcs, rx_crc, rx_crc_next;
    logic [LW-1:0] rx_wr, rx_rd, rx_avail, rx_rd_next, rx_avail_next;
    logic [7:0]    rx_buf [FIFO_DEPTH];

    assign tx_ready = (tx_state == TX_IDLE && !rx_data_valid) ||
                      (tx_state == TX_LOAD && tx_len != DEPTH_L);

    // Byte about to go on the wire: header shift register, or payload once LEN is done
    assign tx_crc_byte = (tx_state == TX_PAY || (tx_state == TX_LEN && tx_cnt == LEN_BYTES))
                         ? tx_buf[tx_rd[AW-1:0]] : hdr[111:104];

    eth_crc32_step u_tx_crc (.crc_in(tx_crc), .data(tx_crc_byte), .crc_out(tx_crc_next));
    eth_crc32_step u_rx_crc (.crc_in(rx_crc), .data(tx_data_out), .crc_out(rx_crc_next));

    always_ff @(posedge clk) begin
        if (tx_state == TX_LOAD && tx_data_valid && tx_ready)
            tx_buf[tx_len[AW-1:0]] <= tx_data_in;
        if (tx_strobe && rx_state == RX_PAY)
            rx_buf[rx_wr[AW-1:0]] <= tx_data_out;
    end

    // tx_cnt counts bytes of the current field already placed on the wire
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_len      <= '0;
            tx_rd       <= '0;
            dst_l       <= '0;
            hdr         <= '0;
            tx_crc      <= CRC_INIT;
            tx_data_out <= 8'h00;
            tx_done     <= 1'b0;
            tx_strobe   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: if (tx_start && !rx_data_valid) begin
                    dst_l         <= dest_mac;
                    hdr[111:16]   <= {dest_mac, src_mac};
                    tx_len        <= '0;
                    tx_state      <= TX_LOAD;
                end
                TX_LOAD: begin
                    if (tx_data_valid && tx_ready) begin
                        tx_len <= tx_len + 1'b1;
                    end else if (tx_len != '0) begin
                        hdr[15:0]   <= 16'(tx_len);
                        tx_data_out <= PREAMBLE_BYTE;
                        tx_strobe   <= 1'b1;
                        tx_cnt      <= 3'd1;
                        tx_crc      <= CRC_INIT;
                        tx_rd       <= '0;
                        tx_state    <= TX_PRE;
                    end
                end
                TX_PRE: begin
                    tx_cnt      <= tx_cnt + 1'b1;
                    tx_data_out <= PREAMBLE_BYTE;
                    if (tx_cnt == PREAMBLE_LEN) begin
                        tx_data_out <= SFD;
                        tx_state    <= TX_SFD;
                    end
                end
                TX_FCS: begin
                    tx_data_out <= ~tx_crc[7:0];
                    tx_crc      <= {8'h00, tx_crc[31:8]};
                    tx_cnt      <= tx_cnt + 1'b1;
                    if (tx_cnt == FCS_BYTES) begin
                        tx_data_out <= 8'h00;
                        tx_strobe   <= 1'b0;
                        tx_done     <= 1'b1;
                        tx_state    <= TX_DONE;
                    end
                end
                TX_DONE: tx_state <= TX_IDLE;
                default: begin
                    if (tx_state == TX_PAY && tx_rd == tx_len) begin
                        tx_data_out <= ~tx_crc[7:0];
                        tx_crc      <= {8'h00, tx_crc[31:8]};
                        tx_cnt      <= 3'd1;
                        tx_state    <= TX_FCS;
                    end else begin
                        tx_data_out <= tx_crc_byte;
                        tx_crc      <= tx_crc_next;
                        hdr         <= {hdr[103:0], 8'h00};
                        tx_cnt      <= tx_cnt + 1'b1;
                        if (tx_state == TX_PAY || (tx_state == TX_LEN && tx_cnt == LEN_BYTES))
                            tx_rd <= tx_rd + 1'b1;
                        if (tx_state == TX_SFD) begin
                            tx_state <= TX_DST;
                            tx_cnt   <= 3'd1;
                        end else if (tx_state == TX_DST && tx_cnt == MAC_BYTES) begin
                            tx_state <= TX_SRC;
                            tx_cnt   <= 3'd1;
                        end else if (tx_state == TX_SRC && tx_cnt == MAC_BYTES) begin
                            tx_state <= TX_LEN;
                            tx_cnt   <= 3'd1;
                        end else if (tx_state == TX_LEN && tx_cnt == LEN_BYTES) begin
                            tx_state <= TX_PAY;
                        end
                    end
                end
            endcase
        end
    end

    assign rx_commit = (rx_state == RX_CHECK) && (rx_dst == dst_l) && (rx_fcs == ~rx_crc);

    always_comb begin
        rx_rd_next    = rx_rd;
        rx_avail_next = rx_avail;
        if (rx_data_valid && rx_data_ready)
            rx_rd_next = rx_rd + 1'b1;
        if (rx_commit) begin
            rx_avail_next = rx_wr;
            rx_rd_next    = '0;
        end
    end

    assign rx_data_out = rx_data_valid ? rx_buf[rx_rd[AW-1:0]] : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state      <= RX_HUNT;
            rx_seen_pre   <= 1'b0;
            rx_cnt        <= '0;
            rx_dst        <= '0;
            rx_len        <= '0;
            rx_fcs        <= '0;
            rx_crc        <= CRC_INIT;
            rx_wr         <= '0;
            rx_rd         <= '0;
            rx_avail      <= '0;
            rx_data_valid <= 1'b0;
        end else begin
            rx_rd         <= rx_rd_next;
            rx_avail      <= rx_avail_next;
            rx_data_valid <= (rx_rd_next != rx_avail_next);
            if (rx_state == RX_CHECK) begin
                rx_state <= RX_HUNT;
            end else if (tx_strobe) begin
                rx_cnt <= rx_cnt + 1'b1;
                if (rx_state inside {RX_DST, RX_SRC, RX_LEN, RX_PAY})
                    rx_crc <= rx_crc_next;
                case (rx_state)
                    RX_HUNT: begin
                        rx_seen_pre <= (tx_data_out == PREAMBLE_BYTE);
                        if (rx_seen_pre && tx_data_out == SFD) begin
                            rx_state <= RX_DST;
                            rx_cnt   <= 3'd1;
                            rx_crc   <= CRC_INIT;
                            rx_wr    <= '0;
                        end
                    end
                    RX_DST: begin
                        rx_dst <= {rx_dst[39:0], tx_data_out};
                        if (rx_cnt == MAC_BYTES) begin
                            rx_state <= RX_SRC;
                            rx_cnt   <= 3'd1;
                        end
                    end
                    RX_SRC: if (rx_cnt == MAC_BYTES) begin
                        rx_state <= RX_LEN;
                        rx_cnt   <= 3'd1;
                    end
                    RX_LEN: begin
                        rx_len <= {rx_len[7:0], tx_data_out};
                        if (rx_cnt == LEN_BYTES)
                            rx_state <= RX_PAY;
                    end
                    RX_PAY: begin
                        rx_wr <= rx_wr + 1'b1;
                        if (16'(rx_wr) + 16'd1 == rx_len) begin
                            rx_state <= RX_FCS;
                            rx_cnt   <= 3'd1;
                        end
                    end
                    RX_FCS: begin
                        rx_fcs <= {tx_data_out, rx_fcs[31:8]};
                        if (rx_cnt == FCS_BYTES)
                            rx_state <= RX_CHECK;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ethernet_tx_rx.sv
// tb/tb_ethernet_tx_rx.sv - directed and randomized frames against a byte-list frame model
module tb_ethernet_tx_rx;
    logic        clk;
    logic        rst;
    logic        tx_start;
    logic [7:0]  tx_data_in;
    logic        tx_data_valid;
    logic        tx_ready;
    logic        tx_done;
    logic [7:0]  tx_data_out;
    logic [7:0]  rx_data_out;
    logic        rx_data_valid;
    logic        rx_data_ready;
    logic [47:0] src_mac;
    logic [47:0] dest_mac;

    int          vecs = 0;
    int          errs = 0;
    logic [7:0]  pay [0:127];
    logic [47:0] cur_src, cur_dst;
    int          cur_n;

    ethernet_tx_rx #(.FIFO_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data_in(tx_data_in),
        .tx_data_valid(tx_data_valid), .tx_ready(tx_ready), .tx_done(tx_done),
        .tx_data_out(tx_data_out), .rx_data_out(rx_data_out), .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready), .src_mac(src_mac), .dest_mac(dest_mac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc32_ref(input logic [7:0] q[$], input int from);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = from; i < q.size(); i++) begin
            c = c ^ {24'h000000, q[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Starts at a negedge with TX idle; returns at the negedge where LOAD is ending
    task automatic start_frame(input logic [47:0] s, input logic [47:0] d, input int n);
        cur_src  = s;
        cur_dst  = d;
        src_mac  = s;
        dest_mac = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        cur_n = 0;
        for (int i = 0; i < n; i++) begin
            tx_data_in    = pay[i];
            tx_data_valid = 1'b1;
            if (!tx_ready) break;
            cur_n++;
            @(negedge clk);
        end
        tx_data_valid = 1'b0;
        tx_data_in    = 8'h00;
    endtask

    task automatic check_frame(input int poke_at);
        logic [7:0]  q[$];
        logic [31:0] c;
        q = {};
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) q.push_back(cur_dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) q.push_back(cur_src[i*8 +: 8]);
        q.push_back(8'(cur_n >> 8));
        q.push_back(8'(cur_n));
        for (int i = 0; i < cur_n; i++) q.push_back(pay[i]);
        c = crc32_ref(q, 8);
        for (int i = 0; i < 4; i++) q.push_back(c[i*8 +: 8]);
        @(negedge clk);
        for (int i = 0; i < q.size(); i++) begin
            chk8("frame_byte", tx_data_out, q[i]);
            if (i == 0) chk1("tx_done_in_frame", tx_done, 1'b0);
            tx_start = (i == poke_at);
            if (i == poke_at) src_mac = ~cur_src;
            @(negedge clk);
        end
        tx_start = 1'b0;
        chk1("tx_done_pulse", tx_done, 1'b1);
        chk8("tx_idle_byte", tx_data_out, 8'h00);
        chk1("rx_valid_at_done", rx_data_valid, 1'b0);
        @(negedge clk);
        chk1("tx_done_cleared", tx_done, 1'b0);
        chk1("rx_valid_rise", rx_data_valid, 1'b1);
    endtask

    task automatic drain(input int n, input bit rnd);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 4000) begin
            rx_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rx_data_valid && rx_data_ready) begin
                chk8("rx_byte", rx_data_out, pay[k]);
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        rx_data_ready = 1'b0;
        chk_int("rx_count", k, n);
        chk1("rx_valid_after_drain", rx_data_valid, 1'b0);
    endtask

    initial begin
        int n;
        rst = 1'b0; tx_start = 1'b0; tx_data_in = 8'h00; tx_data_valid = 1'b0;
        rx_data_ready = 1'b0; src_mac = '0; dest_mac = '0;
        repeat (3) @(negedge clk);
        chk1("reset_tx_ready", tx_ready, 1'b1);
        chk1("reset_tx_done", tx_done, 1'b0);
        chk8("reset_tx_data_out", tx_data_out, 8'h00);
        chk1("reset_rx_valid", rx_data_valid, 1'b0);
        chk8("reset_rx_data_out", rx_data_out, 8'h00);
        rst = 1'b1;
        @(negedge clk);

        // nominal frame, then a start attempt while RX still holds it
        for (int i = 0; i < 16; i++) pay[i] = 8'(8'hBA + i);
        start_frame(48'h112233445566, 48'hAABBCCDDEEFF, 16);
        chk_int("nominal_accepted", cur_n, 16);
        check_frame(-1);
        chk1("pending_tx_ready", tx_ready, 1'b0);
        tx_start = 1'b1; tx_data_valid = 1'b1; tx_data_in = 8'h77;
        @(negedge clk);
        tx_start = 1'b0;
        @(negedge clk);
        tx_data_valid = 1'b0; tx_data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk8("pending_no_frame", tx_data_out, 8'h00);
        chk1("pending_tx_ready_held", tx_ready, 1'b0);
        chk8("pending_rx_head", rx_data_out, 8'hBA);
        drain(16, 1'b0);

        // same frame, random backpressure
        start_frame(48'h112233445566, 48'hAABBCCDDEEFF, 16);
        check_frame(-1);
        drain(16, 1'b1);

        // overfull payload
        for (int i = 0; i < 70; i++) pay[i] = 8'($urandom);
        start_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 70);
        chk_int("full_accepted", cur_n, 64);
        check_frame(-1);
        drain(64, 1'b1);

        // tx_start during payload is ignored
        for (int i = 0; i < 20; i++) pay[i] = 8'($urandom);
        start_frame({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 20);
        check_frame(30);
        drain(20, 1'b1);

        // reset while the source MAC is on the wire
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        start_frame(48'hCAFE00000001, 48'hBEEF00000002, 10);
        @(negedge clk);
        chk8("abort_first_byte", tx_data_out, 8'h55);
        repeat (16) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk8("abort_tx_data_out", tx_data_out, 8'h00);
        chk1("abort_tx_done", tx_done, 1'b0);
        chk1("abort_rx_valid", rx_data_valid, 1'b0);
        chk8("abort_rx_data_out", rx_data_out, 8'h00);
        chk1("abort_tx_ready", tx_ready, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk8("abort_quiet", tx_data_out, 8'h00);
        chk1("abort_rx_quiet", rx_data_valid, 1'b0);
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        start_frame(48'h665544332211, 48'hFFEEDDCCBBAA, 5);
        check_frame(-1);
        drain(5, 1'b1);

        // single zero byte
        pay[0] = 8'h00;
        start_frame(48'h112233445566, 48'hAABBCCDDEEFF, 1);
        chk_int("single_accepted", cur_n, 1);
        check_frame(-1);
        drain(1, 1'b0);

        // random frames
        for (int f = 0; f < 3; f++) begin
            n = $urandom_range(1, 64);
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
            start_frame({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, n);
            chk_int("rand_accepted", cur_n, n);
            check_frame(-1);
            drain(n, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
